rx_jitter_buffer: RTL

Receive-side audio elastic buffer between the decrypted-payload output of the packet manager and the I2S controller's DAC input. It absorbs burst arrival of radio audio words, holds playback until a prefill threshold is reached, and supplies a continuous sample stream to the DAC. On underrun it substitutes filler samples and re-enters prefill. Overruns and underruns are counted for debug.

---
 rtl/rx_jitter_buffer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rx_jitter_buffer.sv
// Receive-side audio elastic buffer: circular FIFO with prefill gating and a DAC output register.
// Optional build macro RX_JB_HOLD_LAST_EN: filler sample repeats the last popped word instead of silence.
module rx_jitter_buffer #(
  parameter int DEPTH_LOG2 = 6,
  parameter int PREFILL    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [15:0]           dac_data,
  output logic                  dac_valid,
  input  logic                  dac_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  playing,
  output logic [15:0]           overrun_cnt,
  output logic [15:0]           underrun_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PREFILL_L = PW'(PREFILL);
  localparam logic [PW-1:0] DEPTH_L   = PW'(DEPTH);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [PW-1:0]       level_q, level_d;
  logic                in_ready_q, in_ready_d;
  logic [15:0]         dac_data_q, dac_data_d;
  logic                dac_valid_q, dac_valid_d;
  logic [15:0]         ovr_q, ovr_d;
  logic [15:0]         und_q, und_d;
  logic [15:0]         mem_q [DEPTH];

  logic                full;
  logic                hs;
  logic                pop;
  logic                wr;
  logic                drop;
  logic                underrun;
  logic [15:0]         head;
  logic [15:0]         filler;

`ifdef RX_JB_HOLD_LAST_EN
  logic [15:0]         last_q, last_d;

  assign filler = last_q;

  always_comb begin
    last_d = last_q;
    if (flush) begin
      last_d = '0;
    end else if (pop) begin
      last_d = head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign filler = '0;
`endif

  // level_q always equals wptr_q - rptr_q, so it doubles as the empty test for pops.
  always_comb begin
    full     = (wptr_q[PW-1] != rptr_q[PW-1]) &&
               (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
    hs       = dac_valid_q && dac_ready;
    pop      = hs && (state_q == ST_PLAY) && (level_q != '0);
    underrun = hs && (state_q == ST_PLAY) && (level_q == '0);
    wr       = in_valid && !full && !flush;
    drop     = in_valid && full && !flush;
    head     = mem_q[rptr_q[PW-2:0]];
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
    end
    level_d    = wptr_d - rptr_d;
    in_ready_d = (level_d != DEPTH_L);
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL: if (level_q >= PREFILL_L) state_d = ST_PLAY;
        ST_PLAY: if (underrun)             state_d = ST_FILL;
        default:                           state_d = ST_FILL;
      endcase
    end
  end

  always_comb begin
    dac_valid_d = 1'b1;
    dac_data_d  = dac_data_q;
    if (hs) begin
      dac_data_d = pop ? head : filler;
    end
    ovr_d = ovr_q;
    if (drop && (ovr_q != '1)) begin
      ovr_d = ovr_q + 1'b1;
    end
    und_d = und_q;
    if (underrun && (und_q != '1)) begin
      und_d = und_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      ovr_q       <= '0;
      und_q       <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
    end
  end

  // Storage needs no reset: contents are only reachable through the reset pointers.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wptr_q[PW-2:0]] <= in_data;
    end
  end

  assign in_ready     = in_ready_q;
  assign dac_data     = dac_data_q;
  assign dac_valid    = dac_valid_q;
  assign level        = level_q;
  assign playing      = (state_q == ST_PLAY);
  assign overrun_cnt  = ovr_q;
  assign underrun_cnt = und_q;

endmodule
